// File: rtl/lsu_mem_ctrl_if.sv
// Signal bundle between the EX stage / data memory and the load-store unit.
// The LSU is the master of the data-memory bus; the environment is the slave side.
interface lsu_mem_ctrl_if;
  logic        ex_valid;
  logic        mem_write;
  logic        memtoreg;
  logic [2:0]  mem_load_type;
  logic [1:0]  mem_store_type;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic        load_valid;
  logic [31:0] load_data;
  logic        misaligned_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    input  ex_valid, mem_write, memtoreg, mem_load_type, mem_store_type,
    input  addr, store_data, dmem_gnt, dmem_rvalid, dmem_rdata,
    output busy, done, load_valid, load_data, misaligned_err,
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata
  );

  modport slave (
    output ex_valid, mem_write, memtoreg, mem_load_type, mem_store_type,
    output addr, store_data, dmem_gnt, dmem_rvalid, dmem_rdata,
    input  busy, done, load_valid, load_data, misaligned_err,
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load-store unit memory controller: aligns/replicates stores, extracts loads,
// and sequences one request/grant/response transaction per accepted access.
module lsu_mem_ctrl (
  input  logic           clk,
  input  logic           rst_n,
  lsu_mem_ctrl_if.master bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [2:0]  ltype_q, ltype_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] ldata_q, ldata_d;
  logic        mis_q, mis_d;

  logic        req_any;
  logic        is_store;
  logic        size_byte;
  logic        size_half;
  logic        aligned;
  logic        accept;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // A request with both mem_write and memtoreg set is a store.
  always_comb begin
    req_any  = bus.ex_valid & (bus.mem_write | bus.memtoreg);
    is_store = bus.mem_write;
    if (is_store) begin
      size_byte = (bus.mem_store_type == 2'b00);
      size_half = (bus.mem_store_type == 2'b01);
    end else begin
      size_byte = (bus.mem_load_type == 3'b000) | (bus.mem_load_type == 3'b011);
      size_half = (bus.mem_load_type == 3'b001) | (bus.mem_load_type == 3'b100);
    end
    aligned = size_byte
            | (size_half & ~bus.addr[0])
            | (~size_byte & ~size_half & (bus.addr[1:0] == 2'b00));
    accept  = (state_q == IDLE) & req_any & aligned;
  end

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = bus.store_data;
    case (bus.mem_store_type)
      2'b00: begin
        st_be    = 4'b0001 << bus.addr[1:0];
        st_wdata = {4{bus.store_data[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << bus.addr[1:0];
        st_wdata = {2{bus.store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = bus.dmem_rdata[{off_q, 3'b000} +: 8];
    ld_half = bus.dmem_rdata[{off_q[1], 4'b0000} +: 16];
    case (ltype_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b011:  ld_ext = {24'd0, ld_byte};
      3'b100:  ld_ext = {16'd0, ld_half};
      default: ld_ext = bus.dmem_rdata;
    endcase
  end

  // Misaligned requests only raise the error pulse; they never leave IDLE.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    ltype_d = ltype_q;
    off_d   = off_q;
    ldata_d = ldata_q;
    mis_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          if (!aligned) begin
            mis_d = 1'b1;
          end else begin
            addr_d  = {bus.addr[31:2], 2'b00};
            be_d    = is_store ? st_be : 4'b0000;
            wdata_d = is_store ? st_wdata : 32'd0;
            we_d    = is_store;
            ltype_d = bus.mem_load_type;
            off_d   = bus.addr[1:0];
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (bus.dmem_gnt) state_d = we_q ? DONE : RESP;
      end
      RESP: begin
        if (bus.dmem_rvalid) begin
          ldata_d = ld_ext;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      ltype_q <= 3'd0;
      off_q   <= 2'd0;
      ldata_q <= 32'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      ltype_q <= ltype_d;
      off_q   <= off_d;
      ldata_q <= ldata_d;
      mis_q   <= mis_d;
    end
  end

  // busy is gated by rst_n so every output reads 0 while reset is held.
  assign bus.busy           = rst_n & ((state_q != IDLE) | accept);
  assign bus.done           = (state_q == DONE);
  assign bus.load_valid     = (state_q == DONE) & ~we_q;
  assign bus.load_data      = ldata_q;
  assign bus.misaligned_err = mis_q;
  assign bus.dmem_req       = (state_q == REQ);
  assign bus.dmem_we        = we_q;
  assign bus.dmem_addr      = addr_q;
  assign bus.dmem_be        = be_q;
  assign bus.dmem_wdata     = wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed vectors plus randomized
// transactions compared every cycle against a transaction-level model.
module tb_lsu_mem_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  lsu_mem_ctrl_if bus ();

  lsu_mem_ctrl dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        expBusy, expDone, expLv, expMis, expReq, expWe, expChkW;
  logic [31:0] expLoad, expAddr, expWdata;
  logic [3:0]  expBe;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Model: access width in bytes and load extension, from the opcode tables.
  function automatic int sizeOf(input bit isStore, input logic [2:0] lt, input logic [1:0] st);
    if (isStore) return (st == 2'd0) ? 1 : (st == 2'd1) ? 2 : 4;
    if (lt == 3'd0 || lt == 3'd3) return 1;
    if (lt == 3'd1 || lt == 3'd4) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] modelBe(input int size, input int off);
    int mask;
    mask = ((1 << size) - 1) << off;
    return mask[3:0];
  endfunction

  function automatic logic [31:0] modelWdata(input int size, input logic [31:0] sdata);
    logic [31:0] w;
    w = 32'd0;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = sdata[8*(k % size) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] lt, input int off, input logic [31:0] rdata);
    int          size;
    longint      val;
    longint      span;
    logic [63:0] res;
    size = sizeOf(1'b0, lt, 2'd0);
    if (size == 4) return rdata;
    span = longint'(1) << (8 * size);
    val  = longint'(rdata >> (8 * off)) % span;
    if ((lt == 3'd0 || lt == 3'd1) && val >= span / 2) val = val - span;
    res = 64'(val);
    return res[31:0];
  endfunction

  always @(negedge clk) begin
    checkOutput("busy", 32'(bus.busy), 32'(expBusy));
    checkOutput("done", 32'(bus.done), 32'(expDone));
    checkOutput("load_valid", 32'(bus.load_valid), 32'(expLv));
    checkOutput("misaligned_err", 32'(bus.misaligned_err), 32'(expMis));
    checkOutput("dmem_req", 32'(bus.dmem_req), 32'(expReq));
    checkOutput("load_data", bus.load_data, expLoad);
    if (expReq) begin
      checkOutput("dmem_addr", bus.dmem_addr, expAddr);
      checkOutput("dmem_we", 32'(bus.dmem_we), 32'(expWe));
      checkOutput("dmem_be", 32'(bus.dmem_be), 32'(expBe));
      if (expChkW) checkOutput("dmem_wdata", bus.dmem_wdata, expWdata);
    end
  end

  task automatic clearExp();
    expBusy = 1'b0; expDone = 1'b0; expLv = 1'b0; expMis = 1'b0;
    expReq  = 1'b0; expChkW = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    clearExp();
    bus.ex_valid    = 1'($urandom);
    bus.mem_write   = 1'b0;
    bus.memtoreg    = 1'b0;
    bus.addr        = $urandom;
    bus.dmem_gnt    = 1'($urandom);
    bus.dmem_rvalid = 1'($urandom);
    bus.dmem_rdata  = $urandom;
    step();
  endtask

  // One access from the accept cycle through done (or the error pulse).
  task automatic applyStimulus(input bit isStore, input logic [2:0] lt, input logic [1:0] st,
                               input logic [31:0] a, input logic [31:0] sdata, input logic [31:0] rdata,
                               input int gntDly, input int rvDly, input bit pin,
                               input logic [3:0] pinBe, input logic [31:0] pinW, input logic [31:0] pinLd);
    int size;
    bit aligned;
    size    = sizeOf(isStore, lt, st);
    aligned = (a % size) == 0;
    clearExp();
    bus.ex_valid       = 1'b1;
    bus.mem_write      = isStore;
    bus.memtoreg       = isStore ? 1'($urandom) : 1'b1;
    bus.mem_load_type  = lt;
    bus.mem_store_type = st;
    bus.addr           = a;
    bus.store_data     = sdata;
    bus.dmem_gnt       = 1'($urandom);
    bus.dmem_rvalid    = 1'($urandom);
    expBusy            = aligned;
    step();
    if (!aligned) begin
      clearExp();
      bus.ex_valid = 1'b0;
      expMis       = 1'b1;
      step();
      return;
    end
    for (int i = 0; i <= gntDly; i++) begin
      clearExp();
      expBusy  = 1'b1;
      expReq   = 1'b1;
      expAddr  = a & 32'hFFFF_FFFC;
      expWe    = isStore;
      expBe    = isStore ? modelBe(size, int'(a % 4)) : 4'b0000;
      expChkW  = isStore;
      expWdata = modelWdata(size, sdata);
      bus.dmem_gnt    = (i == gntDly);
      bus.dmem_rvalid = 1'($urandom);
      bus.dmem_rdata  = $urandom;
      if (pin && isStore && i == 0) begin
        #2;
        checkOutput("pin_be", 32'(bus.dmem_be), 32'(pinBe));
        checkOutput("pin_wdata", bus.dmem_wdata, pinW);
      end
      step();
    end
    if (!isStore) begin
      for (int j = 0; j <= rvDly; j++) begin
        clearExp();
        expBusy         = 1'b1;
        bus.dmem_gnt    = 1'($urandom);
        bus.dmem_rvalid = (j == rvDly);
        bus.dmem_rdata  = (j == rvDly) ? rdata : $urandom;
        step();
      end
    end
    clearExp();
    expBusy         = 1'b1;
    expDone         = 1'b1;
    expLv           = !isStore;
    bus.dmem_gnt    = 1'($urandom);
    bus.dmem_rvalid = 1'($urandom);
    bus.dmem_rdata  = $urandom;
    if (!isStore) begin
      expLoad = modelLoad(lt, int'(a % 4), rdata);
      if (pin) begin
        #2;
        checkOutput("pin_load_data", bus.load_data, pinLd);
      end
    end
    step();
    bus.ex_valid = 1'b0;
  endtask

  // Reset dropped while waiting for read data must abandon the access at once.
  task automatic resetInResp();
    clearExp();
    bus.ex_valid = 1'b1; bus.mem_write = 1'b0; bus.memtoreg = 1'b1;
    bus.mem_load_type = 3'b010; bus.addr = 32'h200;
    bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0;
    expBusy = 1'b1;
    step();
    clearExp();
    expBusy = 1'b1; expReq = 1'b1; expAddr = 32'h200; expWe = 1'b0; expBe = 4'b0000;
    bus.dmem_gnt = 1'b1;
    step();
    clearExp();
    expBusy = 1'b1;
    bus.dmem_gnt = 1'b0;
    #2;
    rst_n = 1'b0;
    clearExp();
    expLoad = 32'd0;
    #1;
    checkOutput("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_load_data", bus.load_data, 32'd0);
    step();
    bus.ex_valid = 1'b0; bus.dmem_rvalid = 1'b1;
    step();
    rst_n = 1'b1;
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'hCAFE_F00D;
    step();
    bus.dmem_rvalid = 1'b0;
    step();
  endtask

  initial begin
    logic [2:0]  lt;
    logic [1:0]  st;
    logic [31:0] a;
    bit          isSt;
    int          sz;
    checks = 0;
    errors = 0;
    expLoad = 32'd0; expAddr = 32'd0; expWdata = 32'd0; expBe = 4'd0; expWe = 1'b0;
    clearExp();
    rst_n = 1'b0;
    bus.ex_valid = 1'b1; bus.mem_write = 1'b1; bus.memtoreg = 1'b0;
    bus.mem_load_type = 3'd2; bus.mem_store_type = 2'd2;
    bus.addr = 32'h100; bus.store_data = 32'h1;
    bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = 32'd0;
    step();
    step();
    rst_n = 1'b1;
    applyStimulus(1'b1, 3'd0, 2'b10, 32'h100, 32'hDEADBEEF, 32'd0, 2, 0, 1'b1, 4'b1111, 32'hDEADBEEF, 32'd0);
    idleCycle();
    applyStimulus(1'b1, 3'd0, 2'b00, 32'h103, 32'h000000A5, 32'd0, 0, 0, 1'b1, 4'b1000, 32'hA5A5A5A5, 32'd0);
    applyStimulus(1'b1, 3'd0, 2'b01, 32'h102, 32'h00001234, 32'd0, 1, 0, 1'b1, 4'b1100, 32'h12341234, 32'd0);
    applyStimulus(1'b0, 3'b000, 2'd0, 32'h102, 32'd0, 32'h12F45678, 0, 0, 1'b1, 4'd0, 32'd0, 32'hFFFFFFF4);
    applyStimulus(1'b0, 3'b011, 2'd0, 32'h102, 32'd0, 32'h12F45678, 1, 1, 1'b1, 4'd0, 32'd0, 32'h000000F4);
    applyStimulus(1'b0, 3'b001, 2'd0, 32'h102, 32'd0, 32'h80015678, 0, 2, 1'b1, 4'd0, 32'd0, 32'hFFFF8001);
    applyStimulus(1'b0, 3'b100, 2'd0, 32'h102, 32'd0, 32'h80015678, 2, 0, 1'b1, 4'd0, 32'd0, 32'h00008001);
    applyStimulus(1'b0, 3'b010, 2'd0, 32'h104, 32'd0, 32'h01234567, 0, 0, 1'b1, 4'd0, 32'd0, 32'h01234567);
    applyStimulus(1'b0, 3'b001, 2'd0, 32'h101, 32'd0, 32'd0, 0, 0, 1'b0, 4'd0, 32'd0, 32'd0);
    applyStimulus(1'b1, 3'd0, 2'b10, 32'h102, 32'h55, 32'd0, 0, 0, 1'b0, 4'd0, 32'd0, 32'd0);
    idleCycle();
    resetInResp();
    for (int n = 0; n < 300; n++) begin
      isSt = 1'($urandom);
      lt   = 3'($urandom_range(0, 7));
      st   = 2'($urandom_range(0, 3));
      a    = $urandom;
      sz   = sizeOf(isSt, lt, st);
      if ($urandom_range(0, 4) != 0) a = a & ~(32'(sz) - 32'd1);
      applyStimulus(isSt, lt, st, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 2),
                    1'b0, 4'd0, 32'd0, 32'd0);
      repeat ($urandom_range(0, 2)) idleCycle();
    end
    idleCycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
